fib_lpm_engine: RTL and testbench

FIB_LPM_ENGINE -- requirements
Module: fib_lpm_engine

---
 rtl/fib_lpm_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_fib_lpm_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fib_lpm_engine.sv
// fib_lpm_engine: hashed, set-associative forwarding table with longest-prefix
// match. A lookup probes one prefix length per cycle, starting at the
// requested length and shortening until it hits or runs out of lengths.
// Insert, delete and clear-all maintain the table. Only one operation is in
// flight at a time, and its response is held until the consumer takes it.
module fib_lpm_engine #(
  parameter int PREFIX_W = 64,
  parameter int LEN_W    = 7,
  parameter int IDX_W    = 6,
  parameter int WAYS     = 2,
  parameter int FACE_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [PREFIX_W-1:0] req_prefix,
  input  logic [LEN_W-1:0]    req_len,
  input  logic [FACE_W-1:0]   req_face,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [1:0]          resp_status,
  output logic [FACE_W-1:0]   resp_face,
  output logic [LEN_W-1:0]    resp_len
);

  localparam int BUCKETS = 1 << IDX_W;
  localparam int NSLICE  = (PREFIX_W + IDX_W - 1) / IDX_W;
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(PREFIX_W);

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_MISS   = 2'b01;
  localparam logic [1:0] ST_FULL   = 2'b10;
  localparam logic [1:0] ST_BADLEN = 2'b11;

  typedef enum logic [2:0] {IDLE, PROBE, WRITE, CLEAR, RESP} state_t;

  state_t state, state_n;

  // Table storage: only the valid bits need resetting.
  logic [WAYS-1:0]     tbl_valid  [BUCKETS];
  logic [PREFIX_W-1:0] tbl_prefix [BUCKETS][WAYS];
  logic [LEN_W-1:0]    tbl_len    [BUCKETS][WAYS];
  logic [FACE_W-1:0]   tbl_face   [BUCKETS][WAYS];

  // Captured request; len_q doubles as the shrinking probe length on lookups.
  logic [1:0]          op_q;
  logic [PREFIX_W-1:0] prefix_q;
  logic [LEN_W-1:0]    len_q;
  logic [FACE_W-1:0]   face_q;
  logic [IDX_W-1:0]    clr_cnt;

  logic [PREFIX_W-1:0] key_mask;
  logic [IDX_W-1:0]    key_idx;
  logic                any_hit;
  logic                any_free;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    free_way;
  logic                bad_len;

  // Keep the top l bits of p, zero the rest; l == 0 yields the default route.
  function automatic logic [PREFIX_W-1:0] mask_prefix(
    input logic [PREFIX_W-1:0] p,
    input logic [LEN_W-1:0]    l
  );
    logic [PREFIX_W-1:0] m;
    for (int i = 0; i < PREFIX_W; i++) begin
      m[i] = p[i] & (i >= (PREFIX_W - int'(l)));
    end
    return m;
  endfunction

  // XOR-fold the masked prefix into IDX_W-bit slices from the LSB upward
  // (top slice zero-padded), then fold in the low bits of the length so the
  // same prefix at different lengths tends to land in different buckets.
  function automatic logic [IDX_W-1:0] hash_key(
    input logic [PREFIX_W-1:0] masked,
    input logic [LEN_W-1:0]    l
  );
    logic [NSLICE*IDX_W-1:0] padded;
    logic [IDX_W-1:0]        h;
    padded = '0;
    padded[PREFIX_W-1:0] = masked;
    h = '0;
    for (int s = 0; s < NSLICE; s++) begin
      h = h ^ padded[s*IDX_W +: IDX_W];
    end
    for (int i = 0; i < IDX_W; i++) begin
      if (i < LEN_W) h[i] = h[i] ^ l[i];
    end
    return h;
  endfunction

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign bad_len    = ({1'b0, req_len} > MAX_LEN);

  // Probe the bucket for the captured key: find the lowest matching way and
  // the lowest free way (descending loop so the lowest index wins).
  always_comb begin
    key_mask = mask_prefix(prefix_q, len_q);
    key_idx  = hash_key(key_mask, len_q);
    any_hit  = 1'b0;
    any_free = 1'b0;
    hit_way  = '0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (tbl_valid[key_idx][w] && (tbl_len[key_idx][w] == len_q) &&
          (tbl_prefix[key_idx][w] == key_mask)) begin
        any_hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!tbl_valid[key_idx][w]) begin
        any_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  // Next-state selection for the operation sequencer.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_op == OP_CLEAR)      state_n = CLEAR;
          else if (bad_len)            state_n = RESP;
          else if (req_op == OP_LOOKUP) state_n = PROBE;
          else                         state_n = WRITE;
        end
      end
      PROBE:   if (any_hit || (len_q == '0)) state_n = RESP;
      WRITE:   state_n = RESP;
      CLEAR:   if (clr_cnt == '1) state_n = RESP;
      RESP:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register, request capture, table updates and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= '0;
      clr_cnt     <= '0;
      resp_status <= '0;
      resp_face   <= '0;
      resp_len    <= '0;
      for (int b = 0; b < BUCKETS; b++) tbl_valid[b] <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q     <= req_op;
            prefix_q <= req_prefix;
            len_q    <= req_len;
            face_q   <= req_face;
            clr_cnt  <= '0;
            if ((req_op != OP_CLEAR) && bad_len) begin
              resp_status <= ST_BADLEN;
              resp_face   <= '0;
              resp_len    <= '0;
            end
          end
        end
        PROBE: begin
          if (any_hit) begin
            resp_status <= ST_OK;
            resp_face   <= tbl_face[key_idx][hit_way];
            resp_len    <= len_q;
          end else if (len_q == '0) begin
            resp_status <= ST_MISS;
            resp_face   <= '0;
            resp_len    <= '0;
          end else begin
            len_q <= len_q - LEN_W'(1);
          end
        end
        WRITE: begin
          resp_face <= '0;
          resp_len  <= '0;
          if (op_q == OP_INSERT) begin
            if (any_hit) begin
              tbl_face[key_idx][hit_way] <= face_q;
              resp_status <= ST_OK;
            end else if (any_free) begin
              tbl_valid[key_idx][free_way]  <= 1'b1;
              tbl_prefix[key_idx][free_way] <= key_mask;
              tbl_len[key_idx][free_way]    <= len_q;
              tbl_face[key_idx][free_way]   <= face_q;
              resp_status <= ST_OK;
            end else begin
              resp_status <= ST_FULL;
            end
          end else if (op_q == OP_DELETE) begin
            if (any_hit) begin
              tbl_valid[key_idx][hit_way] <= 1'b0;
              resp_status <= ST_OK;
            end else begin
              resp_status <= ST_MISS;
            end
          end
        end
        CLEAR: begin
          tbl_valid[clr_cnt] <= '0;
          clr_cnt <= clr_cnt + IDX_W'(1);
          if (clr_cnt == '1) begin
            resp_status <= ST_OK;
            resp_face   <= '0;
            resp_len    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_lpm_engine.sv
// tb_fib_lpm_engine: directed test of the LPM forwarding engine with
// hand-computed expected status, face, length and response latency.
module tb_fib_lpm_engine;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  // p1, p2 and p3 (length 64) all hash to bucket 1: each sets a single bit in
  // a different 6-bit slice, and 64 contributes nothing to the low 6 bits.
  localparam logic [63:0] P1 = 64'h0000_0000_0000_0001;
  localparam logic [63:0] P2 = 64'h0000_0000_0000_0040;
  localparam logic [63:0] P3 = 64'h0000_0000_0000_1000;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [63:0] req_prefix;
  logic [6:0]  req_len;
  logic [3:0]  req_face;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_status;
  logic [3:0]  resp_face;
  logic [6:0]  resp_len;

  int checks = 0;
  int passes = 0;

  fib_lpm_engine dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_prefix  (req_prefix),
    .req_len     (req_len),
    .req_face    (req_face),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_status (resp_status),
    .resp_face   (resp_face),
    .resp_len    (resp_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Release the held response and confirm the engine is ready again next cycle.
  task automatic completeResponse();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    checkOutput("req_ready_after_resp", req_ready, 1);
  endtask

  // Issue one request and wait for its response; latency counts cycles from
  // the accept edge (cycle 0). With hold set, the response is left pending.
  task automatic applyStimulus(input logic [1:0] op, input logic [63:0] prefix,
                               input logic [6:0] len, input logic [3:0] face,
                               input bit hold, output logic [1:0] st,
                               output logic [3:0] fc, output logic [6:0] ln,
                               output int lat, output bit ok);
    int guard;
    st = '0; fc = '0; ln = '0; lat = 0; ok = 1'b0;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checkOutput("req_ready_timeout", req_ready, 1);
      return;
    end
    req_valid  = 1'b1;
    req_op     = op;
    req_prefix = prefix;
    req_len    = len;
    req_face   = face;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_op = 2'b00; req_prefix = '0; req_len = '0; req_face = '0;
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!resp_valid) begin
      checkOutput("resp_timeout", resp_valid, 1);
      return;
    end
    st = resp_status;
    fc = resp_face;
    ln = resp_len;
    ok = 1'b1;
    if (!hold) completeResponse();
  endtask

  task automatic runOp(input string tag, input logic [1:0] op,
                       input logic [63:0] prefix, input logic [6:0] len,
                       input logic [3:0] face, input logic [1:0] exp_st,
                       input int exp_lat, input bit chk_fields,
                       input logic [3:0] exp_face, input logic [6:0] exp_len);
    logic [1:0] st;
    logic [3:0] fc;
    logic [6:0] ln;
    int lat;
    bit ok;
    applyStimulus(op, prefix, len, face, 1'b0, st, fc, ln, lat, ok);
    if (!ok) return;
    checkOutput({tag, ".status"}, st, exp_st);
    checkOutput({tag, ".latency"}, lat, exp_lat);
    if (chk_fields) begin
      checkOutput({tag, ".face"}, fc, exp_face);
      checkOutput({tag, ".len"}, ln, exp_len);
    end
  endtask

  initial begin
    logic [1:0] st;
    logic [3:0] fc;
    logic [6:0] ln;
    int lat;
    bit ok;

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_prefix = '0;
    req_len = '0; req_face = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset values");
    checkOutput("reset.req_ready", req_ready, 1);
    checkOutput("reset.resp_valid", resp_valid, 0);
    checkOutput("reset.resp_status", resp_status, 0);
    checkOutput("reset.resp_face", resp_face, 0);
    checkOutput("reset.resp_len", resp_len, 0);

    $display("[TB] longest-prefix hit");
    runOp("ins_ab8", OP_INSERT, 64'hAB00_0000_0000_0000, 7'd8, 4'd3, 2'b00, 2, 0, 0, 0);
    runOp("lkp_abcd16", OP_LOOKUP, 64'hABCD_0000_0000_0000, 7'd16, 4'd0, 2'b00, 10, 1, 4'd3, 7'd8);
    runOp("upd_ab8", OP_INSERT, 64'hAB00_0000_0000_0000, 7'd8, 4'd5, 2'b00, 2, 0, 0, 0);
    runOp("lkp_upd", OP_LOOKUP, 64'hABFF_0000_0000_0000, 7'd12, 4'd0, 2'b00, 6, 1, 4'd5, 7'd8);

    $display("[TB] delete");
    runOp("del_ab8", OP_DELETE, 64'hAB00_0000_0000_0000, 7'd8, 4'd0, 2'b00, 2, 0, 0, 0);
    runOp("lkp_after_del", OP_LOOKUP, 64'hABCD_0000_0000_0000, 7'd16, 4'd0, 2'b01, 18, 1, 4'd0, 7'd0);
    runOp("del_again", OP_DELETE, 64'hAB00_0000_0000_0000, 7'd8, 4'd0, 2'b01, 2, 0, 0, 0);

    $display("[TB] default route");
    runOp("ins_default", OP_INSERT, 64'hDEAD_BEEF_0000_0000, 7'd0, 4'd7, 2'b00, 2, 0, 0, 0);
    runOp("lkp_default", OP_LOOKUP, 64'h1234_5678_9ABC_DEF0, 7'd64, 4'd0, 2'b00, 66, 1, 4'd7, 7'd0);

    $display("[TB] bad length and clear-all");
    runOp("lkp_len65", OP_LOOKUP, 64'h1234_5678_9ABC_DEF0, 7'd65, 4'd0, 2'b11, 1, 0, 0, 0);
    runOp("ins_len65", OP_INSERT, 64'h1234_5678_9ABC_DEF0, 7'd65, 4'd2, 2'b11, 1, 0, 0, 0);
    runOp("clear_all", OP_CLEAR, 64'h0, 7'd0, 4'd0, 2'b00, 65, 0, 0, 0);
    runOp("lkp_after_clr", OP_LOOKUP, 64'h1234_5678_9ABC_DEF0, 7'd64, 4'd0, 2'b01, 66, 1, 4'd0, 7'd0);

    $display("[TB] bucket full");
    runOp("ins_p1", OP_INSERT, P1, 7'd64, 4'd9, 2'b00, 2, 0, 0, 0);
    runOp("ins_p2", OP_INSERT, P2, 7'd64, 4'd10, 2'b00, 2, 0, 0, 0);
    runOp("ins_p3", OP_INSERT, P3, 7'd64, 4'd11, 2'b10, 2, 0, 0, 0);
    runOp("lkp_p3", OP_LOOKUP, P3, 7'd64, 4'd0, 2'b01, 66, 1, 4'd0, 7'd0);
    runOp("lkp_p2", OP_LOOKUP, P2, 7'd64, 4'd0, 2'b00, 2, 1, 4'd10, 7'd64);

    $display("[TB] response backpressure");
    applyStimulus(OP_LOOKUP, P1, 7'd64, 4'd0, 1'b1, st, fc, ln, lat, ok);
    if (ok) begin
      checkOutput("hold.latency", lat, 2);
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("hold.resp_valid", resp_valid, 1);
        checkOutput("hold.status", resp_status, 2'b00);
        checkOutput("hold.face", resp_face, 4'd9);
        checkOutput("hold.len", resp_len, 7'd64);
        checkOutput("hold.req_ready", req_ready, 0);
      end
      completeResponse();
    end

    $display("[TB] reset mid-lookup");
    @(negedge clk);
    checkOutput("abort.idle", req_ready, 1);
    req_valid = 1'b1; req_op = OP_LOOKUP;
    req_prefix = 64'hFFFF_FFFF_FFFF_FFFF; req_len = 7'd64; req_face = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("abort.busy", req_ready, 0);
      @(posedge clk);
    end
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort.req_ready", req_ready, 1);
    checkOutput("abort.resp_valid", resp_valid, 0);
    runOp("lkp_after_rst", OP_LOOKUP, P1, 7'd64, 4'd0, 2'b01, 66, 1, 4'd0, 7'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
